alu_access_arbiter: RTL and testbench

ALU_ACCESS_ARBITER -- requirements
Module: alu_access_arbiter

---
 rtl/alu_access_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_access_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_access_arbiter.sv
// alu_access_arbiter
// Shares one external ALU between two requesters. A request is granted
// round-robin, its operands are driven to the ALU for one issue cycle plus
// one settle cycle, and the ALU result and flags are captured and held for
// the owning requester until that requester acknowledges them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation; ReqReady offers a grant to a valid requester
// ISSUE   | latched operands on the ALU, ALUWF pulses for one cycle
// CAPTURE | ALU result settled; registered into RespOut/RespFlags
// RESP    | RespValid[owner] held until RespAck[owner]
module alu_access_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNSEL_WIDTH = 5
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [1:0]                ReqValid,
    output logic [1:0]                ReqReady,
    input  logic [2*DATA_WIDTH-1:0]   ReqA,
    input  logic [2*DATA_WIDTH-1:0]   ReqB,
    input  logic [2*FUNSEL_WIDTH-1:0] ReqFunSel,
    input  logic [1:0]                ReqWF,
    output logic [1:0]                RespValid,
    input  logic [1:0]                RespAck,
    output logic [DATA_WIDTH-1:0]     RespOut,
    output logic [3:0]                RespFlags,
    output logic [DATA_WIDTH-1:0]     ALUA,
    output logic [DATA_WIDTH-1:0]     ALUB,
    output logic [FUNSEL_WIDTH-1:0]   ALUFunSel,
    output logic                      ALUWF,
    input  logic [DATA_WIDTH-1:0]     ALUOut,
    input  logic [3:0]                ALUFlags,
    output logic                      Busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arbStateT;

    arbStateT                state;
    logic                    lastGrant;   // index of the requester served last
    logic                    owner;       // index of the requester in flight
    logic [1:0]              grant;
    logic [DATA_WIDTH-1:0]   selA;
    logic [DATA_WIDTH-1:0]   selB;
    logic [FUNSEL_WIDTH-1:0] selFunSel;
    logic                    selWF;

    // Round-robin grant, offered only while idle; on a tie the requester
    // that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            if (ReqValid == 2'b11) begin
                grant = lastGrant ? 2'b01 : 2'b10;
            end else begin
                grant = ReqValid;
            end
        end
    end

    // Pick the granted requester's operand slice.
    always_comb begin
        selA      = ReqA[DATA_WIDTH-1:0];
        selB      = ReqB[DATA_WIDTH-1:0];
        selFunSel = ReqFunSel[FUNSEL_WIDTH-1:0];
        selWF     = ReqWF[0];
        if (grant[1]) begin
            selA      = ReqA[2*DATA_WIDTH-1:DATA_WIDTH];
            selB      = ReqB[2*DATA_WIDTH-1:DATA_WIDTH];
            selFunSel = ReqFunSel[2*FUNSEL_WIDTH-1:FUNSEL_WIDTH];
            selWF     = ReqWF[1];
        end
    end

    assign ReqReady = grant;
    assign Busy     = (state != IDLE);

    // Sequencer: latch on accept, pulse ALUWF in ISSUE, capture at the
    // CAPTURE->RESP edge, release on the owner's acknowledge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            ALUA      <= '0;
            ALUB      <= '0;
            ALUFunSel <= '0;
            ALUWF     <= 1'b0;
            RespValid <= 2'b00;
            RespOut   <= '0;
            RespFlags <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner     <= grant[1];
                        ALUA      <= selA;
                        ALUB      <= selB;
                        ALUFunSel <= selFunSel;
                        ALUWF     <= selWF;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ALUWF <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    RespOut   <= ALUOut;
                    RespFlags <= ALUFlags;
                    RespValid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (RespAck[owner]) begin
                        RespValid <= 2'b00;
                        lastGrant <= owner;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_access_arbiter.sv
// Testbench for alu_access_arbiter. Provides a small ALU model (combinational
// result, registered flags written only by ALUWF) and checks every response
// against a scoreboard filled at request acceptance.
module tb_alu_access_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [63:0] ReqA;
    logic [63:0] ReqB;
    logic [9:0]  ReqFunSel;
    logic [1:0]  ReqWF;
    logic [1:0]  RespValid;
    logic [1:0]  RespAck;
    logic [31:0] RespOut;
    logic [3:0]  RespFlags;
    logic [31:0] ALUA;
    logic [31:0] ALUB;
    logic [4:0]  ALUFunSel;
    logic        ALUWF;
    logic [31:0] ALUOut;
    logic [3:0]  ALUFlags;
    logic        Busy;

    alu_access_arbiter #(.DATA_WIDTH(32), .FUNSEL_WIDTH(5)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA(ReqA), .ReqB(ReqB), .ReqFunSel(ReqFunSel), .ReqWF(ReqWF),
        .RespValid(RespValid), .RespAck(RespAck),
        .RespOut(RespOut), .RespFlags(RespFlags),
        .ALUA(ALUA), .ALUB(ALUB), .ALUFunSel(ALUFunSel), .ALUWF(ALUWF),
        .ALUOut(ALUOut), .ALUFlags(ALUFlags), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    localparam logic [4:0] FS_ADD = 5'b10100;
    localparam logic [4:0] FS_ADC = 5'b10101;
    localparam logic [4:0] FS_SUB = 5'b00110;
    localparam logic [4:0] FS_XOR = 5'b00111;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    int acceptCyc = 0;
    int wfSeen = 0;

    typedef struct {
        logic        own;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        wf;
    } sbEntry;
    sbEntry sbQ[$];

    logic [31:0] lastOut;
    logic [3:0]  lastFlags;
    logic        lastOwn;

    // ALU model: returns {result, Z, C, N, O}
    function automatic logic [35:0] aluCalc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] fs, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        o;
        c = 1'b0;
        o = 1'b0;
        case (fs)
            FS_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            FS_ADC: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                r = s[31:0]; c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            FS_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: begin
                r = a ^ b;
            end
        endcase
        return {r, (r == 32'd0), c, r[31], o};
    endfunction

    logic [3:0]  aluFlagReg = 4'b0000;
    logic        presetEn = 1'b0;
    logic [3:0]  presetVal = 4'b0000;
    logic [35:0] aluNow;

    assign aluNow   = aluCalc(ALUA, ALUB, ALUFunSel, aluFlagReg[2]);
    assign ALUOut   = aluNow[35:4];
    assign ALUFlags = aluFlagReg;

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (presetEn) aluFlagReg <= presetVal;
        else if (ALUWF) aluFlagReg <= aluNow[3:0];
    end

    task automatic chkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Acceptance monitor: pushes the expected response for each accepted request
    logic        monOwn;
    logic [31:0] monA;
    logic [31:0] monB;
    logic [4:0]  monFs;
    logic        monWf;
    logic [35:0] monR;
    always @(negedge Clock) begin
        if ((ReqValid & ReqReady) != 2'b00) begin
            monOwn = ReqReady[1];
            monA   = monOwn ? ReqA[63:32] : ReqA[31:0];
            monB   = monOwn ? ReqB[63:32] : ReqB[31:0];
            monFs  = monOwn ? ReqFunSel[9:5] : ReqFunSel[4:0];
            monWf  = ReqWF[monOwn];
            monR   = aluCalc(monA, monB, monFs, aluFlagReg[2]);
            sbQ.push_back('{monOwn, monR[35:4], (monWf ? monR[3:0] : aluFlagReg), monWf});
            acceptCyc = cyc;
            wfSeen = 0;
            chkVal("grantOneHot", 128'($countones(ReqReady)), 128'd1);
        end else if (ALUWF) begin
            wfSeen++;
        end
    end

    task automatic drive();
        @(posedge Clock);
        #1;
    endtask

    task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] fs, input logic wf);
        if (i == 0) begin
            ReqA[31:0] = a; ReqB[31:0] = b; ReqFunSel[4:0] = fs; ReqWF[0] = wf;
        end else begin
            ReqA[63:32] = a; ReqB[63:32] = b; ReqFunSel[9:5] = fs; ReqWF[1] = wf;
        end
        ReqValid[i] = 1'b1;
    endtask

    task automatic serveNext(input int expOwn, input int hold, input bit wrongAck, input bit pulse);
        bit          got;
        logic [1:0]  g;
        logic        own;
        logic        other;
        sbEntry      e;
        logic [31:0] o;
        logic [3:0]  f;
        got = 1'b0;
        g = 2'b00;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge Clock);
            g = ReqValid & ReqReady;
            if (g != 2'b00) got = 1'b1;
        end
        if (!got) begin
            chkVal("acceptTimeout", 128'd0, 128'd1);
            return;
        end
        chkVal("grantOwner", 128'(g), 128'(2'b01 << expOwn));
        own = g[1];
        other = ~own;
        drive();
        ReqValid[own] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge Clock);
            if (RespValid != 2'b00) got = 1'b1;
        end
        if (!got) begin
            chkVal("respTimeout", 128'd0, 128'd1);
            return;
        end
        chkVal("respLatency", 128'(cyc - acceptCyc), 128'd3);
        chkVal("respValid", 128'(RespValid), 128'(own ? 2'b10 : 2'b01));
        if (sbQ.size() == 0) begin
            chkVal("sbEmpty", 128'd0, 128'd1);
            return;
        end
        e = sbQ.pop_front();
        chkVal("respOut", 128'(RespOut), 128'(e.res));
        chkVal("respFlags", 128'(RespFlags), 128'(e.flg));
        chkVal("aluWfCycles", 128'(wfSeen), 128'(e.wf));
        o = RespOut;
        f = RespFlags;
        lastOut = o;
        lastFlags = f;
        lastOwn = own;
        for (int h = 0; h < hold; h++) begin
            drive();
            if (wrongAck) RespAck = own ? 2'b01 : 2'b10;
            if (pulse) ReqValid[other] = (h == 0);
            @(negedge Clock);
            chkVal("holdValid", 128'(RespValid), 128'(own ? 2'b10 : 2'b01));
            chkVal("holdData", 128'({RespOut, RespFlags}), 128'({o, f}));
            chkVal("holdReady", 128'(ReqReady), 128'd0);
        end
        drive();
        RespAck = own ? 2'b10 : 2'b01;
        drive();
        RespAck = 2'b00;
        chkVal("ackIdle", 128'({Busy, RespValid}), 128'd0);
    endtask

    logic [4:0] fsTab [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        fsTab[0] = FS_ADD; fsTab[1] = FS_ADC; fsTab[2] = FS_SUB; fsTab[3] = FS_XOR;
        Reset = 1'b0;
        ReqValid = 2'b00; ReqA = '0; ReqB = '0; ReqFunSel = '0; ReqWF = 2'b00;
        RespAck = 2'b00;
        lastOwn = 1'b0; lastOut = '0; lastFlags = '0;
        repeat (2) @(negedge Clock);
        chkVal("inReset", 128'({ReqReady, RespValid, RespOut, RespFlags, ALUA, ALUB,
                                ALUFunSel, ALUWF, Busy}), 128'd0);
        drive();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chkVal("idleAfterReset", 128'({ReqReady, RespValid, RespOut, RespFlags, ALUA, ALUB,
                                           ALUFunSel, ALUWF, Busy}), 128'd0);
        end

        // Single R0 add
        drive();
        setReq(0, 32'h1234_1234, 32'h4321_4321, FS_ADD, 1'b1);
        serveNext(0, 0, 1'b0, 1'b0);
        chkVal("addOut", 128'(lastOut), 128'(32'h5555_5555));
        chkVal("addFlags", 128'(lastFlags), 128'(4'b0000));

        // Both valid: R1 favoured after R0; R1 held 10 cycles with wrong-bit ack
        drive();
        setReq(0, 32'h0000_0005, 32'h0000_0007, FS_SUB, 1'b1);
        setReq(1, 32'h8000_0000, 32'h0000_0001, FS_SUB, 1'b1);
        serveNext(1, 10, 1'b1, 1'b0);
        serveNext(0, 0, 1'b0, 1'b0);
        chkVal("subOut", 128'(lastOut), 128'(32'hFFFF_FFFE));

        // Reset during CAPTURE discards the operation
        drive();
        setReq(0, 32'hAAAA_0000, 32'h0000_5555, FS_ADD, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge Clock);
            if ((ReqValid & ReqReady) != 2'b00) got = 1'b1;
        end
        chkVal("rstAccept", 128'(got), 128'd1);
        drive();
        ReqValid = 2'b00;
        drive();
        Reset = 1'b0;
        #1;
        chkVal("rstImmediate", 128'({ReqReady, RespValid, RespOut, RespFlags, ALUA, ALUB,
                                     ALUFunSel, ALUWF, Busy}), 128'd0);
        if (sbQ.size() > 0) sbQ.delete(0);
        drive();
        drive();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chkVal("rstNoResp", 128'({Busy, RespValid}), 128'd0);
        end

        // After reset, simultaneous requests: R0 first; R1 adc with C preset
        drive();
        presetVal = 4'b0100;
        presetEn = 1'b1;
        drive();
        presetEn = 1'b0;
        setReq(0, 32'h0F0F_0F0F, 32'h00FF_00FF, FS_XOR, 1'b0);
        setReq(1, 32'h7777_7777, 32'h8888_8888, FS_ADC, 1'b1);
        serveNext(0, 0, 1'b0, 1'b0);
        chkVal("xorOut", 128'(lastOut), 128'(32'h0FF0_0FF0));
        chkVal("noWfFlagsPreset", 128'(lastFlags), 128'(4'b0100));
        serveNext(1, 0, 1'b0, 1'b0);
        chkVal("adcOut", 128'(lastOut), 128'(32'h0000_0000));
        chkVal("adcFlags", 128'(lastFlags), 128'(4'b1100));

        // WF=0 returns the previous flags
        drive();
        setReq(0, 32'd1, 32'd2, FS_ADD, 1'b0);
        serveNext(0, 0, 1'b0, 1'b0);
        chkVal("noWfOut", 128'(lastOut), 128'd3);
        chkVal("noWfFlags", 128'(lastFlags), 128'(4'b1100));

        // Continuous contention alternates grants
        drive();
        setReq(0, $urandom, $urandom, fsTab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        setReq(1, $urandom, $urandom, fsTab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        for (int k = 0; k < 6; k++) begin
            serveNext(lastOwn ? 0 : 1, 0, 1'b0, 1'b0);
            setReq(int'(lastOwn), $urandom, $urandom, fsTab[$urandom_range(0, 3)],
                   1'($urandom_range(0, 1)));
        end
        serveNext(lastOwn ? 0 : 1, 0, 1'b0, 1'b0);
        serveNext(lastOwn ? 0 : 1, 0, 1'b0, 1'b0);

        // A request dropped before acceptance leaves no trace
        drive();
        setReq(1, 32'h0000_00F0, 32'h0000_000F, FS_XOR, 1'b1);
        serveNext(1, 3, 1'b0, 1'b1);
        repeat (4) @(negedge Clock);
        chkVal("dropIdle", 128'({Busy, RespValid}), 128'd0);
        chkVal("dropNoQueue", 128'(sbQ.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
